// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
package dmem_pkg;
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [23:0] MMIO_BASE  = 24'hFFFFFF;
  localparam logic [7:0]  OFF_TIMER  = 8'h00;
  localparam logic [7:0]  OFF_TXDATA = 8'h04;
  localparam logic [7:0]  OFF_STATUS = 8'h08;

  localparam int ST_OVF     = 4;
  localparam int ST_FULL    = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Reserved encodings (011, 110, 111) fall through to a word access.
  function automatic size_e accessSize(input logic [2:0] f3);
    if (f3 == F3_B || f3 == F3_BU)      return SZ_B;
    else if (f3 == F3_H || f3 == F3_HU) return SZ_H;
    else                                return SZ_W;
  endfunction

  function automatic logic [NUM_LANES-1:0] storeMask(input logic [2:0] f3, input logic [1:0] a);
    case (accessSize(f3))
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data so every enabled lane sees its byte.
  function automatic logic [31:0] storeLanes(input logic [2:0] f3, input logic [31:0] wd);
    case (accessSize(f3))
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] loadExtract(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic        uns;
    sh  = word >> {a, 3'b000};
    b   = sh[7:0];
    h   = a[1] ? word[31:16] : word[15:0];
    uns = (f3 == F3_BU) || (f3 == F3_HU);
    case (accessSize(f3))
      SZ_B:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// M-stage memory bus plus console byte stream.
interface dmem_if;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;

  modport master (output MemWriteM, Funct3M, ALUResultM, WriteDataM, TxReady,
                  input  ReadDataM, TxData, TxValid);
  modport slave  (input  MemWriteM, Funct3M, ALUResultM, WriteDataM, TxReady,
                  output ReadDataM, TxData, TxValid);
endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// Console TX byte FIFO; a push into a full FIFO with no pop drops the byte and sets sticky ovf.
module tx_fifo
  import dmem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [7:0]         pushData,
  input  logic               ready,
  input  logic               clrOvf,
  output logic               valid,
  output logic [7:0]         headData,
  output logic [FIFO_CW-1:0] count,
  output logic               full,
  output logic               ovf
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    slots [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic          pop, accept;

  assign valid    = count != '0;
  assign full     = count == FIFO_CW'(FIFO_DEPTH);
  assign pop      = valid && ready;
  assign accept   = push && (!full || pop);
  assign headData = slots[head];

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        slots[tail] <= pushData;
        tail        <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (clrOvf)              ovf <= 1'b0;
      else if (push && !accept) ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Byte-lane data RAM plus optional MMIO block (TIMER, TXDATA FIFO, STATUS) enabled by DMEM_MMIO_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_LANES-1:0][VEC_W-1:0] mem [DEPTH];
  logic [NUM_LANES-1:0][VEC_W-1:0] wrLanes;
  logic [NUM_LANES-1:0]            byteEn;
  logic [AW-1:0]                   idx;
  logic                            isMmio, ramWe;
  logic [31:0]                     mmioRd, rdData;

  assign idx     = bus.ALUResultM[AW+1:2];
  assign isMmio  = bus.ALUResultM[31:8] == MMIO_BASE;
  assign ramWe   = reset && bus.MemWriteM && !isMmio;
  assign byteEn  = storeMask(bus.Funct3M, bus.ALUResultM[1:0]);
  assign wrLanes = storeLanes(bus.Funct3M, bus.WriteDataM);

  // RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (ramWe)
      for (int i = 0; i < NUM_LANES; i++)
        if (byteEn[i]) mem[idx][i] <= wrLanes[i];
  end

`ifdef DMEM_MMIO_EN
  logic [7:0]         offs;
  logic               mmioWe;
  logic [31:0]        timer, status;
  logic [FIFO_CW-1:0] fCount;
  logic               fFull, fOvf;

  // Registers are word-only: size and addr[1:0] are ignored.
  assign offs   = {bus.ALUResultM[7:2], 2'b00};
  assign mmioWe = reset && bus.MemWriteM && isMmio;

  always_ff @(posedge clk) begin
    if (!reset)                                timer <= '0;
    else if (mmioWe && offs == OFF_TIMER)      timer <= bus.WriteDataM;
    else                                       timer <= timer + 32'd1;
  end

  tx_fifo uTxFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (mmioWe && offs == OFF_TXDATA),
    .pushData (bus.WriteDataM[7:0]),
    .ready    (bus.TxReady),
    .clrOvf   (mmioWe && offs == OFF_STATUS),
    .valid    (bus.TxValid),
    .headData (bus.TxData),
    .count    (fCount),
    .full     (fFull),
    .ovf      (fOvf)
  );

  always_comb begin
    status                = '0;
    status[ST_OVF]        = fOvf;
    status[ST_FULL]       = fFull;
    status[FIFO_CW-1:0]   = fCount;
    case (offs)
      OFF_TIMER:  mmioRd = timer;
      OFF_STATUS: mmioRd = status;
      default:    mmioRd = '0;
    endcase
  end
`else
  assign mmioRd      = '0;
  assign bus.TxValid = 1'b0;
  assign bus.TxData  = '0;
`endif

  // Loads see the array before this edge's store (read-old-data).
  always_comb begin
    rdData = isMmio ? mmioRd : loadExtract(bus.Funct3M, bus.ALUResultM[1:0], mem[idx]);
  end

  assign bus.ReadDataM = reset ? rdData : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-level reference model checked every cycle.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  logic clk;
  logic reset;
  dmem_if bus();

  dmem_responder #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;
  bit chkEn  = 1'b0;

  logic [7:0] mMem   [NB];
  bit         mKnown [NB];
  logic [7:0] q [$];
`ifdef DMEM_MMIO_EN
  logic [31:0] mTimer;
  bit          mOvf;
  bit          mPop;
`endif
  bit          mIsIo;
  logic [5:0]  mOff;
  logic [31:0] cExp;
  bit          cKn;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    end
  endtask

  function automatic int unsigned nBytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] mRead(input logic [2:0] f3, input logic [31:0] a, output bit kn);
    int unsigned n, base;
    logic [31:0] v;
    kn = 1'b1;
    if (a[31:8] == 24'hFFFFFF) begin
`ifdef DMEM_MMIO_EN
      case (a[7:2])
        6'd0:    return mTimer;
        6'd2:    return {27'd0, mOvf, q.size() == 4, 3'(q.size())};
        default: return 32'd0;
      endcase
`else
      return 32'd0;
`endif
    end
    n    = nBytes(f3);
    base = (a & ~(n - 1)) & (NB - 1);
    v    = 32'd0;
    for (int i = 0; i < int'(n); i++) begin
      if (!mKnown[base + i]) kn = 1'b0;
      v = v | ({24'd0, mMem[base + i]} << (8 * i));
    end
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // Reference model: advances once per rising edge from the inputs seen there.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      q.delete();
`ifdef DMEM_MMIO_EN
      mTimer = 32'd0;
      mOvf   = 1'b0;
`endif
    end else begin
      mIsIo = bus.ALUResultM[31:8] == 24'hFFFFFF;
      mOff  = bus.ALUResultM[7:2];
`ifdef DMEM_MMIO_EN
      mPop   = q.size() > 0 && bus.TxReady;
      mTimer = mTimer + 32'd1;
      if (bus.MemWriteM && mIsIo && mOff == 6'd0) mTimer = bus.WriteDataM;
      if (bus.MemWriteM && mIsIo && mOff == 6'd2) mOvf = 1'b0;
      if (mPop) void'(q.pop_front());
      if (bus.MemWriteM && mIsIo && mOff == 6'd1) begin
        if (q.size() < 4) q.push_back(bus.WriteDataM[7:0]);
        else              mOvf = 1'b1;
      end
`endif
      if (bus.MemWriteM && !mIsIo) begin
        int unsigned n, base;
        n    = nBytes(bus.Funct3M);
        base = (bus.ALUResultM & ~(n - 1)) & (NB - 1);
        for (int i = 0; i < int'(n); i++) begin
          mMem[base + i]   = 8'(bus.WriteDataM >> (8 * i));
          mKnown[base + i] = 1'b1;
        end
      end
    end
  end

  // Every-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (chkEn) begin
      cExp = mRead(bus.Funct3M, bus.ALUResultM, cKn);
      if (!reset) begin cExp = 32'd0; cKn = 1'b1; end
      if (cKn) check("model.ReadDataM", bus.ReadDataM, cExp);
      check("model.TxValid", {31'd0, bus.TxValid}, {31'd0, q.size() > 0});
      if (q.size() > 0) check("model.TxData", {24'd0, bus.TxData}, {24'd0, q[0]});
    end
  end

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.MemWriteM  = we;
    bus.Funct3M    = f3;
    bus.ALUResultM = a;
    bus.WriteDataM = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    drive(1'b1, f3, a, wd);
    tick();
    drive(1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  task automatic ld(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, f3, a, 32'h0);
    @(negedge clk);
    check(nm, bus.ReadDataM, exp);
    tick();
  endtask

  initial begin
    reset       = 1'b0;
    bus.TxReady = 1'b0;
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    tick();
    chkEn = 1'b1;
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clk);
    check("rst_rd_zero", bus.ReadDataM, 32'h0);
    check("rst_txvalid", {31'd0, bus.TxValid}, 32'h0);
    tick();
    reset = 1'b1;

`ifdef DMEM_MMIO_EN
    // First cycle after release reads 0, the sixth reads 5.
    drive(1'b0, 3'b010, 32'hFFFFFF00, 32'h0);
    @(negedge clk);
    check("timer_c1", bus.ReadDataM, 32'd0);
    repeat (5) tick();
    @(negedge clk);
    check("timer_c6", bus.ReadDataM, 32'd5);
    tick();
`endif

    st(3'b010, 32'h10, 32'h80FF7F01);
    ld("lb_10",  3'b000, 32'h10, 32'h00000001);
    ld("lb_11",  3'b000, 32'h11, 32'h0000007F);
    ld("lb_12",  3'b000, 32'h12, 32'hFFFFFFFF);
    ld("lhu_12", 3'b101, 32'h12, 32'h000080FF);
    ld("lh_12",  3'b001, 32'h12, 32'hFFFF80FF);
    ld("lw_10",  3'b010, 32'h10, 32'h80FF7F01);

    st(3'b010, 32'h400, 32'hA5A5A5A5);
    ld("wrap_lw0", 3'b010, 32'h0, 32'hA5A5A5A5);

    st(3'b010, 32'h20, 32'h11111111);
    drive(1'b1, 3'b010, 32'h20, 32'h22222222);
    @(negedge clk);
    check("same_cyc_old", bus.ReadDataM, 32'h11111111);
    tick();
    ld("after_store", 3'b010, 32'h20, 32'h22222222);

    st(3'b010, 32'h30, 32'h0);
    st(3'b000, 32'h31, 32'h123456AB);
    ld("sb_lane1", 3'b010, 32'h30, 32'h0000AB00);
    st(3'b001, 32'h33, 32'hCAFEBEEF);
    ld("sh_a0ign", 3'b010, 32'h30, 32'hBEEFAB00);
    ld("lhu_32",   3'b101, 32'h32, 32'h0000BEEF);
    ld("lbu_33",   3'b100, 32'h33, 32'h000000BE);
    ld("lb_33",    3'b000, 32'h33, 32'hFFFFFFBE);
    ld("f3_111",   3'b111, 32'h31, 32'hBEEFAB00);
    ld("f3_011",   3'b011, 32'h33, 32'hBEEFAB00);
    st(3'b010, 32'h42, 32'h13579BDF);
    ld("sw_misal", 3'b010, 32'h40, 32'h13579BDF);

    // MMIO store whose low bits alias RAM word 0x308 must not touch RAM.
    st(3'b010, 32'h308, 32'hDEADBEEF);
    st(3'b010, 32'hFFFFFF08, 32'h12345678);
    ld("mmio_no_ram", 3'b010, 32'h308, 32'hDEADBEEF);

`ifdef DMEM_MMIO_EN
    st(3'b010, 32'hFFFFFF00, 32'hFFFFFFFE);
    ld("tmr_fe", 3'b010, 32'hFFFFFF00, 32'hFFFFFFFE);
    ld("tmr_ff", 3'b010, 32'hFFFFFF00, 32'hFFFFFFFF);
    ld("tmr_00", 3'b010, 32'hFFFFFF00, 32'h00000000);

    st(3'b010, 32'hFFFFFF04, 32'h41);
    st(3'b010, 32'hFFFFFF04, 32'h42);
    st(3'b000, 32'hFFFFFF05, 32'h43);
    st(3'b010, 32'hFFFFFF04, 32'h44);
    st(3'b010, 32'hFFFFFF04, 32'h45);
    drive(1'b0, 3'b010, 32'hFFFFFF08, 32'h0);
    @(negedge clk);
    check("status_1c", bus.ReadDataM, 32'h1C);
    check("txdata_41", {24'd0, bus.TxData}, 32'h41);
    check("txvalid_1", {31'd0, bus.TxValid}, 32'h1);
    tick();
    ld("txdata_rd0", 3'b010, 32'hFFFFFF04, 32'h0);
    st(3'b010, 32'hFFFFFF08, 32'h0);
    ld("status_0c", 3'b010, 32'hFFFFFF08, 32'h0C);

    drive(1'b1, 3'b010, 32'hFFFFFF04, 32'h46);
    bus.TxReady = 1'b1;
    tick();
    bus.TxReady = 1'b0;
    drive(1'b0, 3'b010, 32'hFFFFFF08, 32'h0);
    @(negedge clk);
    check("pushpop_0c", bus.ReadDataM, 32'h0C);
    check("txdata_42", {24'd0, bus.TxData}, 32'h42);
    tick();

    // Drain one byte, then hit reset while still draining with three queued.
    bus.TxReady = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("drain_txdata_43", {24'd0, bus.TxData}, 32'h43);
    check("rst_mid_rd0", bus.ReadDataM, 32'h0);
    tick();
    reset = 1'b1;
    drive(1'b0, 3'b010, 32'hFFFFFF00, 32'h0);
    @(negedge clk);
    check("rst_txvalid0", {31'd0, bus.TxValid}, 32'h0);
    check("rst_timer0", bus.ReadDataM, 32'h0);
    tick();
    bus.TxReady = 1'b0;
    ld("rst_status0", 3'b010, 32'hFFFFFF08, 32'h0);
`else
    ld("off_timer0", 3'b010, 32'hFFFFFF00, 32'h0);
    st(3'b010, 32'hFFFFFF04, 32'h41);
    @(negedge clk);
    check("off_txvalid0", {31'd0, bus.TxValid}, 32'h0);
    check("off_txdata0", {24'd0, bus.TxData}, 32'h0);
    tick();
    bus.TxReady = 1'b1;
    ld("off_status0", 3'b010, 32'hFFFFFF08, 32'h0);
    bus.TxReady = 1'b0;
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_rd0", bus.ReadDataM, 32'h0);
    tick();
    reset = 1'b1;
`endif
    ld("ram_kept", 3'b010, 32'h10, 32'h80FF7F01);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the RAM size in 32-bit words; it must be a power of two.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port MemWriteM, input, 1 bit: store request from the M stage.
REQ-005 SHALL have port Funct3M, input, 3 bits: access size and sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-006 SHALL have port ALUResultM, input, 32 bits: byte address.
REQ-007 SHALL have port WriteDataM, input, 32 bits: store data, right-aligned.
REQ-008 SHALL have port ReadDataM, output, 32 bits: combinational load data, extended per Funct3M.
REQ-009 SHALL have port TxData, output, 8 bits: console byte at the head of the FIFO.
REQ-010 SHALL have port TxValid, output, 1 bit: FIFO is non-empty.
REQ-011 SHALL have port TxReady, input, 1 bit: consumer accepts TxData; a pop occurs when TxValid && TxReady.

Function
REQ-012 SHALL decode the MMIO region as ALUResultM[31:8]==24'hFFFFFF; all other addresses are RAM, indexed by ALUResultM[log2(DEPTH)+1:2], with upper bits ignored (wrap).
REQ-013 SHALL return RAM loads combinationally from the current array contents, so a load in the same cycle as a store to that word returns the old data.
REQ-014 SHALL perform RAM stores at the rising clk edge when MemWriteM=1: sb writes the lane at addr[1:0], sh writes the half at addr[1], and sw writes all 4 bytes; addr[0] is ignored for h, and addr[1:0] is ignored for w.
REQ-015 SHALL extract loads by the same lane rules, sign-extending for b/h and zero-extending for bu/hu.
REQ-016 SHALL treat Funct3M 011, 110 and 111 as a word access.
REQ-017 SHALL implement TIMER at 0xFFFF_FF00: a 32-bit free-running counter that increments every cycle and wraps 0xFFFFFFFF->0; a store loads WriteDataM with priority over the increment.
REQ-018 SHALL implement TXDATA at 0xFFFF_FF04: a store pushes WriteDataM[7:0] into a 4-entry FIFO, and a load returns 0.
REQ-019 SHALL implement STATUS at 0xFFFF_FF08 as {27'b0, ovf, full, count[2:0]}; any store to it clears ovf.
REQ-020 SHALL accept a push when count<4, or when count==4 and a pop occurs in the same cycle; otherwise it drops the byte and sets ovf (sticky).
REQ-021 SHALL, on a simultaneous push and pop, leave count unchanged, move the head forward, and write the new byte at the tail.
REQ-022 SHALL keep TxData stable while TxValid=1 and no pop occurs; TxData is don't-care when empty.
REQ-023 SHALL return 0 for loads from unmapped MMIO offsets and ignore stores to them; MMIO registers are word-only and ignore size and addr[1:0].
REQ-024 SHALL hold ReadDataM at 0 in every cycle with reset=0.

Reset
REQ-025 SHALL, at a clk edge with reset=0, set TIMER=0, set count=0 with head and tail at 0, clear ovf, and drive TxValid=0, discarding any FIFO contents mid-operation.
REQ-026 SHALL NOT reset RAM contents, and SHALL ignore stores while reset=0.

Configuration
REQ-027 SHALL compile the MMIO block in when DMEM_MMIO_EN is defined, giving the TIMER, FIFO and STATUS behaviour of REQ-017 to REQ-023.
REQ-028 SHALL, without DMEM_MMIO_EN, return 0 for MMIO-region loads and ignore MMIO-region stores, tie TxValid=0 and TxData=0, ignore TxReady, and infer no timer or FIFO logic.

Structure
REQ-029 SHALL take the Funct3 load/store encodings, MMIO base and offsets, STATUS bit positions, and FIFO depth (4) from package dmem_pkg.
REQ-030 SHALL place the FIFO in sub-module tx_fifo (push/pop/full/count/ovf), instantiated only under DMEM_MMIO_EN.

Verification
REQ-031 SHALL cover stores and loads: sw 0x80FF7F01 to 0x10, then lb 0x10 -> 0x00000001, lb 0x11 -> 0x0000007F, lb 0x12 -> 0xFFFFFFFF, lhu 0x12 -> 0x000080FF, lh 0x12 -> 0xFFFF80FF.
REQ-032 SHALL cover wrap and ordering: with DEPTH=256, sw 0xA5A5A5A5 to 0x400 -> lw 0x0 returns 0xA5A5A5A5; a same-cycle lw of a word being stored -> old value.
REQ-033 SHALL cover the timer: after reset release, TIMER read N cycles later -> N-1; sw 0xFFFFFFFE to TIMER -> reads 0xFFFFFFFE, 0xFFFFFFFF, then 0x00000000 on successive cycles.
REQ-034 SHALL cover the FIFO: TxReady=0, push 0x41..0x45 -> STATUS=0x1C (ovf=1, full=1, count=4); TxData=0x41; sw STATUS -> 0x0C; with count==4, push plus pop in one cycle -> count stays 4 and the last byte is accepted.
REQ-035 SHALL cover reset: reset=0 mid-drain with count=3 -> next cycle TxValid=0, STATUS=0, TIMER=0, and RAM retains data.
REQ-036 SHALL cover the config-off build: without DMEM_MMIO_EN, lw 0xFFFFFF00 -> 0, sw TXDATA -> TxValid stays 0.
